// File: rtl/act_cfg_loader.sv
// Bit-serial configuration loader for an array of S1 logic cells: shifts a frame into a shadow
// register and commits it atomically. Optional even-parity frame check under ACT_CFG_PARITY_EN.
module act_cfg_loader #(
  parameter int NUM_CELLS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic                     cfg_bit,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  output logic [7*NUM_CELLS-1:0]   cell_cfg,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     cfg_error,
  output logic [1:0]               dbg_state,
  output logic [$clog2(7*NUM_CELLS+1)-1:0] dbg_count
);

  localparam int W  = 7 * NUM_CELLS;
  localparam int CW = $clog2(W + 1);

  // Handshake: a bit transfers on a rising edge where cfg_valid and cfg_ready are both high;
  // cfg_ready depends only on state, and cfg_start overrides (drops) a simultaneous transfer.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_count;
  logic [W-1:0]    r_shadow;
  logic [W-1:0]    r_cell_cfg;
  logic            w_xfer;
  logic            w_last;
  logic            w_par_ok;

  assign cfg_ready = (r_state == S_SHIFT) || (r_state == S_PARITY);
  assign cfg_busy  = (r_state != S_IDLE);
  // An abort landing in COMMIT cancels the commit, so the done pulse is suppressed too.
  assign cfg_done  = (r_state == S_COMMIT) && !cfg_start;
  assign cell_cfg  = r_cell_cfg;
  assign dbg_state = r_state;
  assign dbg_count = r_count;

  assign w_xfer   = cfg_valid && cfg_ready && !cfg_start;
  assign w_last   = (r_count == CW'(W - 1));
  assign w_par_ok = ~(^{r_shadow, cfg_bit});

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (cfg_start) begin
          w_next = S_SHIFT;
        end else if (w_xfer && w_last) begin
`ifdef ACT_CFG_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_COMMIT;
`endif
        end
      end
      S_PARITY: begin
        if (cfg_start) w_next = S_SHIFT;
        else if (w_xfer) w_next = w_par_ok ? S_COMMIT : S_IDLE;
      end
      S_COMMIT: begin
        w_next = cfg_start ? S_SHIFT : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_shadow   <= '0;
      r_cell_cfg <= '0;
    end else begin
      r_state <= w_next;
      if (cfg_start) begin
        r_count  <= '0;
        r_shadow <= '0;
      end else if ((r_state == S_SHIFT) && w_xfer) begin
        r_count  <= r_count + CW'(1);
        r_shadow <= {r_shadow[W-2:0], cfg_bit};
      end
      if ((r_state == S_COMMIT) && !cfg_start) r_cell_cfg <= r_shadow;
    end
  end

`ifdef ACT_CFG_PARITY_EN
  logic r_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (cfg_start) begin
      r_error <= 1'b0;
    end else if ((r_state == S_PARITY) && w_xfer && !w_par_ok) begin
      r_error <= 1'b1;
    end
  end

  assign cfg_error = r_error;
`else
  assign cfg_error = 1'b0;
`endif

endmodule
